api_wb_arb: RTL
===============

// Module: api_wb_arb
// PURPOSE
// - Two-master Wishbone arbiter for the api register/FIFO slave port: M0 = lm32 CPU, M1 = hardware work feeder.
// - Round-robin grant, held for a whole CYC; slave-stall watchdog; grant/error status to the CPU.
// - Sits between the bus masters and the api block's API_* slave inputs.
// PARAMETERS
// - ADR_W      6     address width, matches API_ADR_I
// - DAT_W      32    data width
// - TIMEOUT    1024  cycles of STB without ACK before the watchdog fires (>=2)
// - MAX_BURST  23    acks per grant under API_ARB_BURST_LIMIT_EN (one 736-bit work)
// PORTS
// - CLK_I           in   1      clock
// - RST_N_I         in   1      synchronous active-low reset
// - M0_CYC_I/M1_CYC_I  in  1    master cycle request
// - M0_STB_I/M1_STB_I  in  1    master strobe
// - M0_WE_I/M1_WE_I    in  1    write enable
// - M0_ADR_I/M1_ADR_I  in  ADR_W  address
// - M0_DAT_I/M1_DAT_I  in  DAT_W  write data
// - M0_SEL_I/M1_SEL_I  in  4    byte select
// - M0_ACK_O/M1_ACK_O  out 1    ack to master
// - M0_ERR_O/M1_ERR_O  out 1    watchdog error to master
// - M0_DAT_O/M1_DAT_O  out DAT_W  read data
// - S_CYC_O,S_STB_O,S_WE_O  out 1  to slave
// - S_ADR_O   out ADR_W;  S_DAT_O  out DAT_W;  S_SEL_O  out 4
// - S_ACK_I   in  1      slave ack
// - S_DAT_I   in  DAT_W  slave read data
// - grant     out 2      one-hot current owner ({M1,M0}); 00 = idle
// - err_cnt   out 8      watchdog events, saturating
// BEHAVIOUR
// - Reset: state IDLE, grant=00, last_owner=M1 (M0 wins first tie), all S_* and M*_ACK/ERR = 0, counters = 0, err_cnt = 0.
// - States: IDLE, G0, G1. Registered state; muxes and ACK routing are combinational from state.
// - IDLE: no grant. Cycle N with any CYC -> owner in state at N+1.
//   - Only one CYC: grant it.
//   - Both CYC: grant the master != last_owner.
// - Gn: S_* = Mn inputs; Mn_ACK_O = S_ACK_I, Mn_DAT_O = S_DAT_I; other master ACK/ERR = 0, DAT_O = 0.
// - Release when Mn_CYC_I = 0 in Gn:
//   - other CYC = 1: go directly to G(other).
//   - else: go to IDLE.
//   - last_owner <= n.
// - Zero-wait slave: a one-cycle single access in Gn completes in the first grant cycle.
// - Watchdog: wd_cnt increments each cycle S_STB_O=1 && S_ACK_I=0; clears on ACK or state change.
//   - At wd_cnt == TIMEOUT-1 with still no ACK: Mn_ERR_O = 1 for exactly that cycle, ACK suppressed.
//   - Next state IDLE, last_owner <= n, err_cnt += 1 (saturate at 255).
//   - Master must drop CYC. It is not re-granted while its CYC stays high unless the other master is idle.
// - S_ACK_I while state IDLE is ignored. ERR and ACK are never both high.
// - RST_N_I low mid-transfer: next cycle is the reset state. The in-flight access gets no ACK or ERR.
// CONFIGURATION
// - API_ARB_BURST_LIMIT_EN defined:
//   - ack_cnt counts ACKs in the current grant and clears on every grant change.
//   - When the ACK that makes ack_cnt == MAX_BURST arrives with the other CYC high, next state is G(other); last_owner <= n.
//   - The preempted master sees STB unforwarded (stall) until re-granted.
//   - With the other CYC low, the grant is kept and ack_cnt restarts at 0.
// - Undefined: no ack_cnt logic; a grant is held until the owner drops CYC or the watchdog fires.
// TESTING
// - M0 single write ADR=6'h0C, DAT=32'hDEADBEEF, slave acks in 2 cycles -> S_* match, M0_ACK pulse 1 cycle, grant=01 then 00.
// - M0 and M1 raise CYC in the same cycle after reset -> grant=01 first. On M0 CYC drop -> grant=10 with no IDLE cycle.
// - M1 CYC held for a 30-word burst while M0 requests:
//   - macro on: M1 receives 23 ACKs, then grant=01.
//   - macro off: M1 receives all 30 ACKs before M0 is granted.
// - Slave never acks, TIMEOUT=16 -> M0_ERR_O high on the 16th strobe cycle, grant=00 next cycle, err_cnt=1.
// - Slave withholds ACK for 256 successive accesses -> err_cnt saturates at 255.
// - RST_N_I low during an M1 read wait state -> grant=00, S_CYC_O=0, no ACK/ERR; the first request after reset is served normally.

Source files
------------

// File: rtl/api_wb_arb.sv
// Two-master round-robin Wishbone arbiter for the api slave port with a slave-stall watchdog.
// Define API_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST acks when the other master is waiting.
module api_wb_arb #(
  parameter int ADR_W     = 6,
  parameter int DAT_W     = 32,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_BURST = 23
) (
  input  logic             CLK_I,
  input  logic             RST_N_I,
  input  logic             M0_CYC_I,
  input  logic             M0_STB_I,
  input  logic             M0_WE_I,
  input  logic [ADR_W-1:0] M0_ADR_I,
  input  logic [DAT_W-1:0] M0_DAT_I,
  input  logic [3:0]       M0_SEL_I,
  output logic             M0_ACK_O,
  output logic             M0_ERR_O,
  output logic [DAT_W-1:0] M0_DAT_O,
  input  logic             M1_CYC_I,
  input  logic             M1_STB_I,
  input  logic             M1_WE_I,
  input  logic [ADR_W-1:0] M1_ADR_I,
  input  logic [DAT_W-1:0] M1_DAT_I,
  input  logic [3:0]       M1_SEL_I,
  output logic             M1_ACK_O,
  output logic             M1_ERR_O,
  output logic [DAT_W-1:0] M1_DAT_O,
  output logic             S_CYC_O,
  output logic             S_STB_O,
  output logic             S_WE_O,
  output logic [ADR_W-1:0] S_ADR_O,
  output logic [DAT_W-1:0] S_DAT_O,
  output logic [3:0]       S_SEL_O,
  input  logic             S_ACK_I,
  input  logic [DAT_W-1:0] S_DAT_I,
  output logic [1:0]       grant,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0   = 2'd1;
  localparam logic [1:0] ST_G1   = 2'd2;

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic            last_owner;
  logic            last_owner_nx;
  logic [WD_W-1:0] wd_cnt;
  logic [7:0]      err_q;
  logic            in_grant;
  logic            owner;
  logic            own_cyc;
  logic            oth_cyc;
  logic [1:0]      oth_state;
  logic            wd_fire;
  logic            ack_fwd;
  logic            burst_hit;

  assign in_grant  = (state == ST_G0) || (state == ST_G1);
  assign owner     = (state == ST_G1);
  assign own_cyc   = owner ? M1_CYC_I : M0_CYC_I;
  assign oth_cyc   = owner ? M0_CYC_I : M1_CYC_I;
  assign oth_state = owner ? ST_G0 : ST_G1;

  // The slave side is a pure mux of the owning master; nothing is forwarded while idle.
  always_comb begin
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_SEL_O  = '0;
    M0_DAT_O = '0;
    M1_DAT_O = '0;
    case (state)
      ST_G0: begin
        S_CYC_O  = M0_CYC_I;
        S_STB_O  = M0_STB_I;
        S_WE_O   = M0_WE_I;
        S_ADR_O  = M0_ADR_I;
        S_DAT_O  = M0_DAT_I;
        S_SEL_O  = M0_SEL_I;
        M0_DAT_O = S_DAT_I;
      end
      ST_G1: begin
        S_CYC_O  = M1_CYC_I;
        S_STB_O  = M1_STB_I;
        S_WE_O   = M1_WE_I;
        S_ADR_O  = M1_ADR_I;
        S_DAT_O  = M1_DAT_I;
        S_SEL_O  = M1_SEL_I;
        M1_DAT_O = S_DAT_I;
      end
      default: ;
    endcase
  end

  // A reset cycle aborts the in-flight access silently, so ACK and ERR are masked by RST_N_I.
  assign wd_fire  = in_grant && S_STB_O && !S_ACK_I && (wd_cnt == WD_LAST);
  assign ack_fwd  = in_grant && S_ACK_I && RST_N_I;
  assign M0_ACK_O = ack_fwd && (state == ST_G0);
  assign M1_ACK_O = ack_fwd && (state == ST_G1);
  assign M0_ERR_O = wd_fire && RST_N_I && (state == ST_G0);
  assign M1_ERR_O = wd_fire && RST_N_I && (state == ST_G1);

  assign grant   = {state == ST_G1, state == ST_G0};
  assign err_cnt = err_q;

`ifdef API_ARB_BURST_LIMIT_EN
  localparam int               ACK_W    = $clog2(MAX_BURST + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(MAX_BURST - 1);

  logic [ACK_W-1:0] ack_cnt;

  assign burst_hit = ack_fwd && (ack_cnt == ACK_LAST);

  // With nobody waiting the owner keeps the bus and starts a fresh burst window.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      ack_cnt <= '0;
    end else if (state_nx != state) begin
      ack_cnt <= '0;
    end else if (ack_fwd) begin
      ack_cnt <= (ack_cnt == ACK_LAST) ? '0 : ack_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_max_burst;

  assign unused_max_burst = 32'(MAX_BURST);
  assign burst_hit        = 1'b0;
`endif

  // Ties in IDLE go to the master that did not own the bus last.
  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    case (state)
      ST_IDLE: begin
        if (M0_CYC_I && M1_CYC_I) begin
          state_nx = last_owner ? ST_G0 : ST_G1;
        end else if (M0_CYC_I) begin
          state_nx = ST_G0;
        end else if (M1_CYC_I) begin
          state_nx = ST_G1;
        end
      end
      ST_G0, ST_G1: begin
        if (wd_fire) begin
          state_nx      = ST_IDLE;
          last_owner_nx = owner;
        end else if (!own_cyc) begin
          state_nx      = oth_cyc ? oth_state : ST_IDLE;
          last_owner_nx = owner;
        end else if (burst_hit && oth_cyc) begin
          state_nx      = oth_state;
          last_owner_nx = owner;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // The watchdog only measures one uninterrupted stall within a single grant.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      wd_cnt     <= '0;
      err_q      <= '0;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      if ((state_nx != state) || S_ACK_I) begin
        wd_cnt <= '0;
      end else if (S_STB_O) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_fire && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

endmodule
